// File: rtl/pipe_stall_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_sched_pkg
// Description : Shared definitions for the pipeline stall/flush scheduler:
//               PC redirect select encodings and scheduler FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_sched_pkg;

  // PC mux select encodings
  localparam logic [1:0] REDIR_PC4  = 2'd0;
  localparam logic [1:0] REDIR_BR   = 2'd1;
  localparam logic [1:0] REDIR_TRAP = 2'd2;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MD_WAIT    = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_sched_sat_counter32.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter32
// Description : 32-bit event counter with enable that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled cycles, holding at the maximum value once reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stall_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_sched
// Description : Central stall/flush scheduler for the 5-stage pipeline.
//               Merges load-use, branch, mul/div, data-memory wait and trap
//               requests into prioritized per-stage stall/flush enables and
//               a PC redirect select; keeps stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_sched
  import pipe_stall_sched_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 64,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lu_stall,
  input  logic        br_taken,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        trap_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  redirect_sel,
  output logic        md_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int c_wd_w = $clog2(MD_MAX_CYCLES + 1);
  localparam int c_dr_w = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(MD_MAX_CYCLES);
  localparam logic [c_dr_w-1:0] c_dr_max = c_dr_w'(DRAIN_CYCLES);

  sched_state_t      r_state, w_next_state;
  logic [c_wd_w-1:0] r_wd, w_wd_next, w_wd_inc;
  logic [c_dr_w-1:0] r_dr, w_dr_next, w_dr_inc;
  logic              w_timeout_set;
  logic              w_mem_wait;

  assign w_mem_wait = dmem_req & ~dmem_ready;
  assign w_wd_inc   = r_wd + 1'b1;
  assign w_dr_inc   = r_dr + 1'b1;

  // State, watchdog, drain counter and sticky timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wd       <= '0;
      r_dr       <= '0;
      md_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wd    <= w_wd_next;
      r_dr    <= w_dr_next;
      if (w_timeout_set) begin
        md_timeout <= 1'b1;
      end
    end
  end

  // Prioritized stall/flush/redirect decode and next-state logic
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    redirect_sel  = REDIR_PC4;
    w_next_state  = r_state;
    w_wd_next     = r_wd;
    w_dr_next     = r_dr;
    w_timeout_set = 1'b0;

    if (w_mem_wait) begin
      // Memory wait freezes the whole pipe; everything else waits its turn
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (trap_req) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            redirect_sel = REDIR_TRAP;
            w_next_state = ST_TRAP_DRAIN;
            w_dr_next    = '0;
          end else if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_sel = REDIR_BR;
          end else if (md_start) begin
            // Start and done together is a single-cycle op: no stall at all
            if (!md_done) begin
              pc_stall     = 1'b1;
              if_id_stall  = 1'b1;
              id_ex_stall  = 1'b1;
              ex_mem_flush = 1'b1;
              w_next_state = ST_MD_WAIT;
              w_wd_next    = '0;
            end
          end else if (lu_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            w_next_state = ST_RUN;
          end else begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            w_wd_next    = w_wd_inc;
            if (w_wd_inc == c_wd_max) begin
              w_timeout_set = 1'b1;
              w_next_state  = ST_RUN;
            end
          end
        end
        ST_TRAP_DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          w_dr_next   = w_dr_inc;
          if (w_dr_inc == c_dr_max) begin
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_stall),
    .count (stall_cnt)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect_sel != REDIR_PC4),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_sched
// Description : Self-checking bench for pipe_stall_sched: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stall_sched;

  localparam int MD_MAX = 4;
  localparam int DRAIN  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu_stall = 1'b0, br_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0, trap_req = 1'b0;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  redirect_sel;
  logic        md_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_stall_sched #(.MD_MAX_CYCLES(MD_MAX), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .lu_stall(lu_stall), .br_taken(br_taken), .md_start(md_start),
    .md_done(md_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .trap_req(trap_req),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .redirect_sel(redirect_sel),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the pipe is busy with, and event tallies
  bit     m_in_md;
  int     m_waited;
  int     m_drain_left;
  bit     m_to;
  longint m_sc, m_fc;
  logic [4:0] e_st;   // {pc, if_id, id_ex, ex_mem, mem_wb} stalls
  logic [2:0] e_fl;   // {if_id, id_ex, ex_mem} flushes
  logic [1:0] e_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_in_md = 0; m_waited = 0; m_drain_left = 0; m_to = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_outputs();
    e_st = 5'b0; e_fl = 3'b0; e_rd = 2'd0;
    if (dmem_req && !dmem_ready) begin
      e_st = 5'b11111;
    end else if (m_drain_left > 0) begin
      e_st = 5'b10000; e_fl = 3'b100;
    end else if (m_in_md) begin
      if (!md_done) begin e_st = 5'b11100; e_fl = 3'b001; end
    end else if (trap_req) begin
      e_fl = 3'b111; e_rd = 2'd2;
    end else if (br_taken) begin
      e_fl = 3'b110; e_rd = 2'd1;
    end else if (md_start) begin
      if (!md_done) begin e_st = 5'b11100; e_fl = 3'b001; end
    end else if (lu_stall) begin
      e_st = 5'b11000; e_fl = 3'b010;
    end
  endtask

  task automatic model_step();
    if (e_st[4]) m_sc = sat_inc(m_sc);
    if (e_rd != 2'd0) m_fc = sat_inc(m_fc);
    if (dmem_req && !dmem_ready) begin
      // pipe frozen: nothing advances
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end else if (m_in_md) begin
      if (md_done) m_in_md = 0;
      else begin
        m_waited++;
        if (m_waited == MD_MAX) begin m_to = 1; m_in_md = 0; end
      end
    end else if (trap_req) begin
      m_drain_left = DRAIN;
    end else if (!br_taken && md_start && !md_done) begin
      m_in_md = 1; m_waited = 0;
    end
  endtask

  // One clock cycle starting at a falling edge
  task automatic drive(input bit lu, input bit br, input bit ms, input bit md,
                       input bit dr, input bit dy, input bit tr);
    lu_stall = lu; br_taken = br; md_start = ms; md_done = md;
    dmem_req = dr; dmem_ready = dy; trap_req = tr;
    #1;
    model_outputs();
    chk("stalls", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall}, e_st);
    chk("flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, e_fl);
    chk("redirect_sel", redirect_sel, e_rd);
    @(posedge clk);
    model_step();
    #1;
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    chk("md_timeout", md_timeout, m_to);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset applied away from the clock edge, then released
  task automatic do_reset();
    lu_stall = 0; br_taken = 0; md_start = 0; md_done = 0;
    dmem_req = 0; dmem_ready = 0; trap_req = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_outputs", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                        if_id_flush, id_ex_flush, ex_mem_flush, redirect_sel, md_timeout}, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Idle RUN: everything quiet
    idle(2);

    // Single load-use cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    idle(1);

    // Branch overrides load-use
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("br_flush_cnt", flush_cnt, 1);

    // Mul/div: start, four waits, done in the sixth cycle
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("md_stall_cnt", stall_cnt, 6);

    // Single-cycle mul/div: no stall
    drive(0, 0, 1, 1, 0, 0, 0);

    // Watchdog: done never comes
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("md_timeout_set", md_timeout, 1);
    idle(3);
    chk("md_timeout_sticky", md_timeout, 1);

    // Branch held across three memory wait cycles
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 1, 1, 0);
    chk("memwait_stall_cnt", stall_cnt, 14);
    chk("memwait_flush_cnt", flush_cnt, 2);

    // Trap entry and drain
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    chk("trap_flush_cnt", flush_cnt, 1);
    chk("trap_stall_cnt", stall_cnt, 2);

    // Reset in the middle of a drain
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    do_reset();
    idle(2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit lu, br, ms, md, dr, dy, tr;
      if (n % 150 == 149) do_reset();
      dr = ($urandom_range(0, 9) < 3);
      dy = $urandom_range(0, 1);
      tr = !m_in_md && ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 6) == 0);
      ms = ($urandom_range(0, 9) == 0);
      md = m_in_md ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 7) == 0);
      lu = !ms && ($urandom_range(0, 4) == 0);
      drive(lu, br, ms, md, dr, dy, tr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
